jtopl_pg_seq: RTL

Time-multiplexed phase generator for the FM operator pipeline: for each operator slot in turn it converts frequency number, block, vibrato offset and multiplier into a phase increment and advances that slot's phase accumulator. Phase state for every slot lives in an internal circular store. The block sits between the register/channel sequencer and the envelope/operator stages, and is parametrised for slot count and widths so the OPL and OPLL-style variants share one implementation.

---
 rtl/jtopl_pg_pkg.sv | 20 ++
 rtl/jtopl_pg_seq_if.sv | 30 +++
 rtl/jtopl_pg_phinc.sv | 46 ++++
 rtl/jtopl_pg_seq.sv | 104 ++++++++++
 4 files changed

// File: rtl/jtopl_pg_pkg.sv
// Shared constants for the FM phase generator: default widths, multiplier table, slot-counter width.
// Optional vibrato path is enabled by defining JTOPL_PG_PM_EN (see jtopl_pg_phinc).
package jtopl_pg_pkg;

  localparam int SLOTS_DEF = 18;
  localparam int FW_DEF    = 10;
  localparam int BW_DEF    = 3;
  localparam int PHW_DEF   = 19;

  // Entry 0 is the halving case and is never used as a factor.
  localparam logic [3:0] MUL_TABLE [16] = '{
    4'd0,  4'd1,  4'd2,  4'd3,  4'd4,  4'd5,  4'd6,  4'd7,
    4'd8,  4'd9,  4'd10, 4'd10, 4'd12, 4'd12, 4'd15, 4'd15
  };

  function automatic int slot_width(input int slots);
    return (slots > 1) ? $clog2(slots) : 1;
  endfunction

endpackage

// File: rtl/jtopl_pg_seq_if.sv
// Per-slot operator inputs and phase outputs of the phase generator.
interface jtopl_pg_seq_if
  import jtopl_pg_pkg::*;
#(
  parameter int SLOTS = SLOTS_DEF,
  parameter int FW    = FW_DEF,
  parameter int BW    = BW_DEF
) ();
  localparam int SW = slot_width(SLOTS);

  logic          zero;
  logic [FW-1:0] fnum;
  logic [BW-1:0] block;
  logic [3:0]    pm_offset;
  logic [3:0]    mul;
  logic          keyon;
  logic [9:0]    phase_out;
  logic [SW-1:0] slot_out;
  logic          valid;

  modport master (
    output zero, fnum, block, pm_offset, mul, keyon,
    input  phase_out, slot_out, valid
  );

  modport slave (
    input  zero, fnum, block, pm_offset, mul, keyon,
    output phase_out, slot_out, valid
  );
endinterface

// File: rtl/jtopl_pg_phinc.sv
// Combinational phase-increment: frequency/block/vibrato to increment, then multiplier scaling.
// Vibrato offset is only applied when JTOPL_PG_PM_EN is defined.
module jtopl_pg_phinc
  import jtopl_pg_pkg::*;
#(
  parameter int FW  = FW_DEF,
  parameter int BW  = BW_DEF,
  parameter int PHW = PHW_DEF
) (
  input  logic [FW-1:0]  fnum,
  input  logic [BW-1:0]  block,
  input  logic [3:0]     pm_offset,
  input  logic [3:0]     mul,
  output logic [PHW-1:0] phinc
);
  localparam int FRW = FW + (1 << BW) - 1;
  localparam int PW  = (FRW + 4 > PHW) ? FRW + 4 : PHW;

  logic [FW:0]    sum;
  logic [FRW:0]   shifted;
  logic [FRW-1:0] freq;
  logic [PW-1:0]  prod;

`ifdef JTOPL_PG_PM_EN
  // One extra bit keeps fnum near full scale plus a positive offset from wrapping negative.
  logic signed [FW+1:0] sum_s;
  always_comb begin
    sum_s = $signed({2'b00, fnum}) + $signed({{(FW-2){pm_offset[3]}}, pm_offset});
    sum   = sum_s[FW+1] ? '0 : sum_s[FW:0];
  end
`else
  logic unused_pm;
  assign unused_pm = ^pm_offset;
  assign sum       = {1'b0, fnum};
`endif

  // NOTE: every combinational output gets a value on every path, so no latch is inferred.
  always_comb begin
    shifted = {{(FRW-FW){1'b0}}, sum} << block;
    freq    = shifted[FRW:1];
    if (mul == 4'd0) prod = PW'(freq >> 1);
    else             prod = PW'(freq) * PW'(MUL_TABLE[mul]);
    phinc   = prod[PHW-1:0];
  end

endmodule

// File: rtl/jtopl_pg_seq.sv
// Time-multiplexed phase generator: three cen-gated stages (sample, increment, accumulate)
// over a rotating per-slot phase store. Build option: JTOPL_PG_PM_EN.
module jtopl_pg_seq
  import jtopl_pg_pkg::*;
#(
  parameter int SLOTS = SLOTS_DEF,
  parameter int FW    = FW_DEF,
  parameter int BW    = BW_DEF,
  parameter int PHW   = PHW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  jtopl_pg_seq_if.slave bus
);
  localparam int            SW   = slot_width(SLOTS);
  localparam logic [SW-1:0] LAST = SW'(SLOTS - 1);

  // Stage 1: the slot counter tags the inputs sampled alongside it.
  logic [SW-1:0]  cnt;
  logic [FW-1:0]  fnum_d1;
  logic [BW-1:0]  block_d1;
  logic [3:0]     pm_d1;
  logic [3:0]     mul_d1;
  logic           keyon_d1;
  // Stage 2
  logic [PHW-1:0] phinc;
  logic [PHW-1:0] phinc_d2;
  logic [SW-1:0]  slot_d2;
  logic           keyon_d2;
  // Stage 3
  logic [PHW-1:0] store [SLOTS];
  logic [PHW-1:0] next_phase;
  logic [PHW-1:0] phase;
  logic [SW-1:0]  slot_q;
  logic           sync_d1, sync_d2, valid_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      fnum_d1  <= '0;
      block_d1 <= '0;
      pm_d1    <= '0;
      mul_d1   <= '0;
      keyon_d1 <= 1'b0;
      sync_d1  <= 1'b0;
    end else if (cen) begin
      cnt      <= (bus.zero || cnt == LAST) ? '0 : cnt + SW'(1);
      fnum_d1  <= bus.fnum;
      block_d1 <= bus.block;
      pm_d1    <= bus.pm_offset;
      mul_d1   <= bus.mul;
      keyon_d1 <= bus.keyon;
      sync_d1  <= sync_d1 | bus.zero;
    end
  end

  jtopl_pg_phinc #(.FW(FW), .BW(BW), .PHW(PHW)) u_phinc (
    .fnum      (fnum_d1),
    .block     (block_d1),
    .pm_offset (pm_d1),
    .mul       (mul_d1),
    .phinc     (phinc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phinc_d2 <= '0;
      slot_d2  <= '0;
      keyon_d2 <= 1'b0;
      sync_d2  <= 1'b0;
    end else if (cen) begin
      phinc_d2 <= phinc;
      slot_d2  <= cnt;
      keyon_d2 <= keyon_d1;
      sync_d2  <= sync_d1;
    end
  end

  // The oldest store entry belongs to the slot now leaving stage 2.
  assign next_phase = keyon_d2 ? '0 : store[SLOTS-1] + phinc_d2;

  // NOTE: the phase store is reset on purpose; every slot must restart from a known zero phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SLOTS; i++) store[i] <= '0;
      phase   <= '0;
      slot_q  <= '0;
      valid_q <= 1'b0;
    end else if (cen) begin
      store[0] <= next_phase;
      for (int i = 1; i < SLOTS; i++) store[i] <= store[i-1];
      phase   <= next_phase;
      slot_q  <= slot_d2;
      valid_q <= sync_d2;
    end
  end

  assign bus.phase_out = phase[PHW-1 -: 10];
  assign bus.slot_out  = slot_q;
  assign bus.valid     = valid_q;

endmodule
